alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
// - Registered decode stage that drives the ALU. Turns an RV32I instruction plus register-file
//   read data into alu_control and operands A and B.
// - Sits between fetch/regfile read and the 32-bit ALU. Produces the 4-bit alu_control encoding
//   the ALU consumes: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl,
//   0111 sra, 1000 slt, 1001 sltu.
// - Uses a valid/ready handshake on both sides and one pipeline register with flush.
// PARAMETERS
// - XLEN      32   datapath width; only 32 is supported
// - SHAMT_W   5    shift-amount width used to mask operand B for shifts
// PORTS
// - clk          in   1     rising-edge clock
// - reset_n      in   1     synchronous, active-low reset
// - in_valid     in   1     upstream presents instr/pc/rs1_data/rs2_data
// - in_ready     out  1     stage can accept this cycle
// - instr        in   32    instruction word
// - pc           in   32    instruction address
// - rs1_data     in   32    register-file read port 1
// - rs2_data     in   32    register-file read port 2
// - flush        in   1     kill the held entry and the entry being accepted
// - out_valid    out  1     decoded entry held
// - out_ready    in   1     ALU stage consumes this cycle
// - alu_control  out  4     ALU opcode, encoding above
// - alu_a        out  32    ALU operand A
// - alu_b        out  32    ALU operand B
// - rd_addr      out  5     destination register
// - reg_write    out  1     write-back enable; forced to 0 when rd = x0
// - is_branch    out  1     BRANCH instruction; funct3 is on br_funct3
// - br_funct3    out  3     funct3 of the branch
// - illegal      out  1     unsupported encoding (only with ILLEGAL_TRAP_EN)
// BEHAVIOUR
// - Reset (reset_n = 0 at a clk edge): all outputs 0. in_ready = 1 on the following cycle.
// - in_ready = !out_valid | out_ready. Combinational; no dependency on in_valid.
// - Accept = in_valid & in_ready. On accept the decode is registered, so latency is 1 cycle.
// - out_valid rules:
//   - Set on accept.
//   - Cleared when out_ready & !accept.
//   - Simultaneous consume and accept: the new entry is loaded and out_valid stays 1.
// - While out_valid & !out_ready, all outputs are held stable.
// - flush: out_valid = 0 next cycle and the same-cycle accept is discarded. Flush wins over
//   accept. in_ready is unaffected.
// - Reset mid-operation discards any held entry.
// - Decode by opcode:
//   - OP 0110011: A = rs1, B = rs2. funct3/funct7 select the op; funct7 = 0100000 gives sub/sra.
//   - OP-IMM 0010011: A = rs1, B = sign-extended imm_i. No sub form. slli/srli/srai use imm[11:5].
//   - Shifts: B = {27'b0, value[4:0]}, because the ALU shifts by the full B.
//   - LUI 0110111: A = 0, B = {imm[31:12], 12'b0}, add.
//   - AUIPC 0010111: A = pc, B = U-immediate, add.
//   - LOAD 0000011: A = rs1, B = imm_i, add. STORE 0100011: A = rs1, B = imm_s, add,
//     reg_write = 0.
//   - BRANCH 1100011: A = rs1, B = rs2, sub, is_branch = 1, reg_write = 0.
//   - JAL 1101111 / JALR 1100111: A = pc, B = 4, add, reg_write = 1.
// - Legality:
//   - funct7 must be 0000000, or 0100000 for add/sub and srl/sra.
//   - Any other opcode or funct7 is illegal.
// - Illegal entries still occupy the stage and are handshaked normally.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined:
//   - illegal = 1 for an unsupported encoding. alu_control = 0000, reg_write = 0.
//   - A 32-bit saturating counter illegal_count is kept; it is readable by hierarchy and
//     reset to 0.
// - ILLEGAL_TRAP_EN undefined:
//   - illegal is tied to 0 and there is no counter.
//   - Unsupported encodings decode as NOP: add, A = B = 0, reg_write = 0.
// TESTING
// - Reset: hold reset_n = 0 for 2 cycles -> all outputs 0, then in_ready = 1.
// - instr 0x002081B3 (add x3,x1,x2), rs1 = 5, rs2 = 7 -> next cycle: out_valid = 1,
//   alu_control = 0000, A = 5, B = 7, rd = 3, reg_write = 1.
// - instr 0x40335293 (srai x5,x6,3), rs1 = 0x80000000 -> alu_control = 0111, B = 3.
//   Then 0x402081B3 (sub) -> alu_control = 0001.
// - instr 0x123450B7 (lui x1) -> A = 0, B = 0x12345000, alu_control = 0000.
// - Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable.
//   Then out_ready = 1 -> next entry loads in the same cycle and no entry is lost.
// - flush together with an accept -> out_valid = 0 next cycle.
//   instr 0x4020C1B3 -> illegal = 1 (macro on), or a NOP with reg_write = 0 (macro off).

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode producing alu_control and operands A/B behind a valid/ready handshake.
// Ports: clk, reset_n (sync, active-low); in_valid/in_ready, instr, pc, rs1_data, rs2_data (upstream);
// flush; out_valid/out_ready, alu_control, alu_a, alu_b, rd_addr, reg_write, is_branch, br_funct3, illegal (to ALU).
// Optional feature macro ILLEGAL_TRAP_EN: drives illegal and keeps a saturating illegal_count.
module alu_decode_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            is_branch,
  output logic [2:0]      br_funct3,
  output logic            illegal
);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  function automatic logic [3:0] f3_ctl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_ctl = alt ? 4'b0001 : 4'b0000;
      3'b001:  f3_ctl = 4'b0101;
      3'b010:  f3_ctl = 4'b1000;
      3'b011:  f3_ctl = 4'b1001;
      3'b100:  f3_ctl = 4'b0010;
      3'b101:  f3_ctl = alt ? 4'b0111 : 4'b0110;
      3'b110:  f3_ctl = 4'b0011;
      default: f3_ctl = 4'b0100;
    endcase
  endfunction
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic [3:0]      d_ctl;
  logic [XLEN-1:0] d_a, d_b;
  logic            d_wr, d_br, d_ill, accept;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  // reset_n gating keeps every output low while reset is asserted
  assign in_ready = reset_n & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  always_comb begin
    d_ctl = 4'b0000;
    d_a   = '0;
    d_b   = '0;
    d_wr  = 1'b0;
    d_br  = 1'b0;
    d_ill = 1'b0;
    case (opc)
      OP_REG: begin
        d_ill = !(f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
        d_ctl = f3_ctl(f3, f7[5]);
        d_a   = rs1_data;
        // the ALU shifts by all of B, so shift amounts are masked here
        d_b   = (f3 == 3'b001 || f3 == 3'b101) ? {{(XLEN-SHAMT_W){1'b0}}, rs2_data[SHAMT_W-1:0]} : rs2_data;
        d_wr  = 1'b1;
      end
      OP_IMM: begin
        d_ill = f3 == 3'b001 ? f7 != 7'b0 : f3 == 3'b101 ? !(f7 == 7'b0 || f7 == F7_ALT) : 1'b0;
        d_ctl = f3_ctl(f3, f3 == 3'b101 && f7[5]);
        d_a   = rs1_data;
        d_b   = (f3 == 3'b001 || f3 == 3'b101) ? {{(XLEN-SHAMT_W){1'b0}}, instr[20+:SHAMT_W]} : imm_i;
        d_wr  = 1'b1;
      end
      OP_LUI: begin
        d_b  = imm_u;
        d_wr = 1'b1;
      end
      OP_AUI: begin
        d_a  = pc;
        d_b  = imm_u;
        d_wr = 1'b1;
      end
      OP_LD: begin
        d_a  = rs1_data;
        d_b  = imm_i;
        d_wr = 1'b1;
      end
      OP_ST: begin
        d_a = rs1_data;
        d_b = imm_s;
      end
      OP_BR: begin
        d_ctl = 4'b0001;
        d_a   = rs1_data;
        d_b   = rs2_data;
        d_br  = 1'b1;
      end
      OP_JAL, OP_JLR: begin
        d_a  = pc;
        d_b  = XLEN'(4);
        d_wr = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctl = 4'b0000;
      d_a   = '0;
      d_b   = '0;
      d_wr  = 1'b0;
      d_br  = 1'b0;
    end
    d_wr = d_wr & (rd != 5'd0);
  end
`ifdef ILLEGAL_TRAP_EN
  logic [31:0] illegal_count;
  always_ff @(posedge clk)
    if (!reset_n) illegal_count <= '0;
    else if (accept && !flush && d_ill && illegal_count != '1) illegal_count <= illegal_count + 32'd1;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rd_addr     <= '0;
      reg_write   <= 1'b0;
      is_branch   <= 1'b0;
      br_funct3   <= '0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_control <= d_ctl;
      alu_a       <= d_a;
      alu_b       <= d_b;
      rd_addr     <= rd;
      reg_write   <= d_wr;
      is_branch   <= d_br;
      br_funct3   <= d_br ? f3 : 3'b000;
`ifdef ILLEGAL_TRAP_EN
      illegal     <= d_ill;
`else
      illegal     <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: table-driven directed checks of alu_decode_stage plus handshake corner sequences.
module tb_alu_decode_stage;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic        reg_write, is_branch, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd_addr;
  logic [2:0]  br_funct3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .rd_addr(rd_addr), .reg_write(reg_write),
    .is_branch(is_branch), .br_funct3(br_funct3), .illegal(illegal)
  );
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wr, br;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;
`ifdef ILLEGAL_TRAP_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif
  vec_t vecs[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask
  initial begin
    vecs[0]  = '{32'h002081B3, 0, 5, 7, 4'h0, 5, 7, 3, 1, 0, 0, 0};
    vecs[1]  = '{32'h40335293, 0, 32'h80000000, 0, 4'h7, 32'h80000000, 3, 5, 1, 0, 0, 0};
    vecs[2]  = '{32'h402081B3, 0, 10, 3, 4'h1, 10, 3, 3, 1, 0, 0, 0};
    vecs[3]  = '{32'h123450B7, 0, 32'hDEADBEEF, 1, 4'h0, 0, 32'h12345000, 1, 1, 0, 0, 0};
    vecs[4]  = '{32'h00001117, 32'h100, 9, 9, 4'h0, 32'h100, 32'h1000, 2, 1, 0, 0, 0};
    vecs[5]  = '{32'hFFF00093, 0, 32'h55, 0, 4'h0, 32'h55, 32'hFFFFFFFF, 1, 1, 0, 0, 0};
    vecs[6]  = '{32'hFE20AE23, 0, 32'h1000, 8, 4'h0, 32'h1000, 32'hFFFFFFFC, 28, 0, 0, 0, 0};
    vecs[7]  = '{32'h0020C063, 0, 11, 22, 4'h1, 11, 22, 0, 0, 1, 4, 0};
    vecs[8]  = '{32'h000000EF, 32'h200, 3, 3, 4'h0, 32'h200, 4, 1, 1, 0, 0, 0};
    vecs[9]  = '{32'h00209233, 0, 1, 32'h25, 4'h5, 1, 5, 4, 1, 0, 0, 0};
    vecs[10] = '{32'h0020B2B3, 0, 6, 32'h25, 4'h9, 6, 32'h25, 5, 1, 0, 0, 0};
    vecs[11] = '{32'h00208033, 0, 1, 2, 4'h0, 1, 2, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h4020C1B3, 0, 1, 2, 4'h0, 0, 0, 3, 0, 0, 0, ILL};
    vecs[13] = '{32'h0000007F, 0, 1, 2, 4'h0, 0, 0, 0, 0, 0, 0, ILL};
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_outputs", {alu_a | alu_b, 32'({alu_control, rd_addr, reg_write, is_branch, br_funct3, illegal})}[31:0] | alu_a | alu_b, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("v%0d_ctl", k), 32'(alu_control), 32'(vecs[k].ctl));
      chk($sformatf("v%0d_a", k), alu_a, vecs[k].a);
      chk($sformatf("v%0d_b", k), alu_b, vecs[k].b);
      chk($sformatf("v%0d_rd", k), 32'(rd_addr), 32'(vecs[k].rd));
      chk($sformatf("v%0d_wr", k), 32'(reg_write), 32'(vecs[k].wr));
      chk($sformatf("v%0d_br", k), 32'(is_branch), 32'(vecs[k].br));
      chk($sformatf("v%0d_f3", k), 32'(br_funct3), 32'(vecs[k].f3));
      chk($sformatf("v%0d_ill", k), 32'(illegal), 32'(vecs[k].ill));
    end
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_count", dut.illegal_count, 2);
`endif
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    drive(32'h002081B3, 0, 5, 7);
    in_valid = 1'b1;
    tick();
    drive(32'h402081B3, 0, 10, 3);
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 0);
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("bp%0d_ctl", k), 32'(alu_control), 0);
      chk($sformatf("bp%0d_b", k), alu_b, 7);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_ctl", 32'(alu_control), 1);
    chk("bp_next_a", alu_a, 10);
    tick();
    chk("bp_drain_valid", 32'(out_valid), 0);
    drive(32'h002081B3, 0, 5, 7);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_accept_valid", 32'(out_valid), 0);
    flush = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("load_valid", 32'(out_valid), 1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_held_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("reload_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_b", alu_b, 0);
    chk("midrst_wr", 32'(reg_write), 0);
`ifdef ILLEGAL_TRAP_EN
    chk("midrst_count", dut.illegal_count, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
